// File: rtl/cpu_types_pkg.sv
// ------------------------------------------------------------------
// cpu_types_pkg : shared CPU word and instruction-cache state types
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef logic [0:0] icache_state_t;
  localparam icache_state_t IDLE = 1'b0;
  localparam icache_state_t FILL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/icache_line_ram.sv
// ------------------------------------------------------------------
// icache_line_ram : data/tag/valid storage, async read, sync write
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module icache_line_ram
  import cpu_types_pkg::*;
#(
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 2,
  parameter int IDX_W       = 4,
  parameter int OFF_W       = 1,
  parameter int TAG_W       = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output word_t            rd_data,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  input  logic             data_we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  word_t            wr_data,
  input  logic             line_we,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             clr_valid
);

  word_t            data  [SETS][BLOCK_WORDS];
  logic [TAG_W-1:0] tags  [SETS];
  logic [SETS-1:0]  valid;

  assign rd_data  = data[rd_idx][rd_off];
  assign rd_tag   = tags[rd_idx];
  assign rd_valid = valid[rd_idx];

  always_ff @(posedge clk) begin
    if (data_we) data[wr_idx][wr_off] <= wr_data;
    if (line_we) tags[wr_idx] <= wr_tag;
  end

  // A clear in the same cycle as a line completion leaves the line invalid.
  always_ff @(posedge clk) begin
    if (rst || clr_valid) begin
      valid <= '0;
    end else if (line_we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/icache_param.sv
// ------------------------------------------------------------------
// icache_param : parametrised direct-mapped icache with block fill
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module icache_param
  import cpu_types_pkg::*;
#(
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  word_t       imemaddr,
  output logic        ihit,
  output word_t       imemload,
  output logic        iREN,
  output word_t       iaddr,
  input  logic        iwait,
  input  word_t       iload,
  input  logic        inv,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int    OFF_BITS   = $clog2(BLOCK_WORDS);
  localparam int    OFF_W      = (OFF_BITS == 0) ? 1 : OFF_BITS;
  localparam int    IDX_W      = $clog2(SETS);
  localparam int    TAG_W      = 30 - OFF_BITS - IDX_W;
  localparam int    LAST_WORD  = BLOCK_WORDS - 1;
  localparam word_t BLOCK_MASK = ~word_t'(BLOCK_WORDS * 4 - 1);

  icache_state_t    state;
  word_t            base;
  logic [OFF_W-1:0] cnt;
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] base_idx;
  logic [TAG_W-1:0] base_tag;
  word_t            rd_data;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_valid;
  logic             accept;
  logic             last;

  generate
    if (OFF_BITS == 0) begin : g_no_off
      assign req_off = '0;
    end else begin : g_off
      assign req_off = imemaddr[2 +: OFF_BITS];
    end
  endgenerate

  assign req_idx  = imemaddr[2 + OFF_BITS +: IDX_W];
  assign req_tag  = imemaddr[31 -: TAG_W];
  assign base_idx = base[2 + OFF_BITS +: IDX_W];
  assign base_tag = base[31 -: TAG_W];

  assign accept   = (state == FILL) && !iwait;
  assign last     = (cnt == OFF_W'(LAST_WORD));

  assign ihit     = (state == IDLE) && imemREN && !inv && rd_valid && (rd_tag == req_tag);
  assign imemload = ihit ? rd_data : '0;
  assign iREN     = (state == FILL);
  assign iaddr    = (state == FILL) ? (base + (word_t'(cnt) << 2)) : '0;

  icache_line_ram #(
    .SETS        (SETS),
    .BLOCK_WORDS (BLOCK_WORDS),
    .IDX_W       (IDX_W),
    .OFF_W       (OFF_W),
    .TAG_W       (TAG_W)
  ) u_ram (
    .clk       (CLK),
    .rst       (RST),
    .rd_idx    (req_idx),
    .rd_off    (req_off),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .data_we   (accept),
    .wr_idx    (base_idx),
    .wr_off    (cnt),
    .wr_data   (iload),
    .line_we   (accept && last && !inv),
    .wr_tag    (base_tag),
    .clr_valid (inv)
  );

  // An invalidate cycle in IDLE suppresses both the hit and a new fill.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      base       <= '0;
      cnt        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit) hit_count <= hit_count + 32'd1;
      case (state)
        IDLE: begin
          if (imemREN && !inv && !ihit) begin
            base       <= imemaddr & BLOCK_MASK;
            cnt        <= '0;
            miss_count <= miss_count + 32'd1;
            state      <= FILL;
          end
        end
        FILL: begin
          if (inv) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (!iwait) begin
            cnt <= cnt + OFF_W'(1);
            if (last) begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
